seq_shift_add_multiplier: RTL and testbench



---
 rtl/seq_shift_add_multiplier.sv | 90 +++++++++
 tb/tb_seq_shift_add_multiplier.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_multiplier.sv
// Radix-2 shift-and-add unsigned multiplier, one multiplier bit per clock.
// Start/done handshake matches the restoring divider so both can share a harness.
module seq_shift_add_multiplier #(
  parameter int unsigned size = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [size:0]      a_in,
  input  logic [size:0]      b_in,
  output logic               busy,
  output logic               done,
  output logic [2*size+1:0]  product
);

  localparam int unsigned Width = size + 1;
  localparam int unsigned AccW  = 2 * Width + 1;
  localparam int unsigned CntW  = (size > 0) ? $clog2(size + 1) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [size:0]     mcand_q;
  logic [AccW-1:0]   acc_q, acc_d;  // {carry, hi, lo}
  logic [CntW-1:0]   cnt_q;
  logic [2*size+1:0] product_q;
  logic [Width:0]    sum;
  logic              last_step;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = StCalc;
      StCalc:  if (last_step) state_d = StDone;
      StDone:  state_d = start ? StLoad : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == StLoad) || (state_q == StCalc);
    done = (state_q == StDone);
  end

  // Add mcand into {carry,hi} when the current multiplier bit is set, keeping the carry,
  // then shift the whole accumulator right with zero entering at the top.
  always_comb begin
    sum       = acc_q[AccW-1:Width] + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_d     = {sum, acc_q[Width-1:0]} >> 1;
    last_step = (cnt_q == CntW'(size));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      case (state_q)
        StLoad: begin
          mcand_q <= a_in;
          acc_q   <= {{(Width + 1){1'b0}}, b_in};
          cnt_q   <= '0;
        end
        StCalc: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CntW'(1);
          if (last_step) product_q <= acc_d[2*Width-1:0];
        end
        default: ;
      endcase
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier: directed cases plus a random sweep
// compared against plain a*b.
module tb_seq_shift_add_multiplier;

  localparam int unsigned Size = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [Size:0]     a_in;
  logic [Size:0]     b_in;
  logic              busy;
  logic              done;
  logic [2*Size+1:0] product;

  int errors = 0;
  int checks = 0;
  int done_count = 0;
  int exp_dones = 0;

  always #5 clk = ~clk;

  seq_shift_add_multiplier #(.size(Size)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always @(negedge clk) if (done) done_count++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits for done after the LOAD edge; returns the edge count since acceptance.
  task automatic wait_done(input logic [2*Size+1:0] prev, input bit scramble, output int n);
    n = 2;
    if (scramble) begin
      a_in = Size'($urandom);
      b_in = Size'($urandom);
    end
    while (!done && n < 40) begin
      check("busy_during_op", busy, 1);
      check("product_held", product, prev);
      tick();
      n++;
    end
  endtask

  task automatic run_op(input logic [Size:0] a, input logic [Size:0] b, input bit scramble);
    int n;
    logic [2*Size+1:0] prev;
    prev  = product;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_load", busy, 1);
    tick();
    wait_done(prev, scramble, n);
    exp_dones++;
    check("latency", n, 9);
    check("busy_with_done", busy, 0);
    check("product", product, int'(a) * int'(b));
  endtask

  initial begin
    int n;
    int dc0;
    int gap;
    logic [Size:0] ra, rb;

    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_product", product, 0);
    rst = 1'b0;
    tick();

    run_op(7'd13, 7'd11, 1'b0);
    tick();
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_hold", product, 143);

    run_op(7'd0, 7'd127, 1'b0);
    run_op(7'd127, 7'd0, 1'b0);
    run_op(7'd127, 7'd127, 1'b0);
    run_op(7'd1, 7'd127, 1'b0);
    tick();

    // start held high; operands change mid-CALC and the DONE-state start relaunches
    dc0   = done_count;
    a_in  = 7'd5;
    b_in  = 7'd6;
    start = 1'b1;
    tick();
    tick();
    a_in = 7'd9;
    b_in = 7'd9;
    wait_done(14'd127, 1'b0, n);
    check("b2b_latency1", n, 9);
    check("b2b_product1", product, 30);
    tick();
    check("b2b_relaunch_busy", busy, 1);
    check("b2b_relaunch_done", done, 0);
    tick();
    wait_done(14'd30, 1'b0, n);
    check("b2b_latency2", n, 9);
    check("b2b_product2", product, 81);
    start = 1'b0;
    tick();
    check("b2b_idle_busy", busy, 0);
    check("b2b_done_count", done_count - dc0, 2);
    exp_dones += 2;

    // reset during the 4th CALC cycle of 100*100
    a_in  = 7'd100;
    b_in  = 7'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_product", product, 0);
    dc0 = done_count;
    repeat (12) tick();
    check("abort_no_done", done_count - dc0, 0);
    run_op(7'd3, 7'd4, 1'b0);

    for (int i = 0; i < 500; i++) begin
      ra = Size'($urandom);
      rb = Size'($urandom);
      run_op(ra, rb, 1'b1);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        a_in = Size'($urandom);
        b_in = Size'($urandom);
        tick();
        check("gap_quiet", {busy, done}, 2'b00);
      end
    end

    repeat (3) tick();
    check("done_total", done_count, exp_dones);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
